// File: rtl/adder_accumulator_pkg.sv
// rtl/adder_accumulator_pkg.sv - shared types, default sizes and saturating counter helper
package adder_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 4;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (value >= max_val) begin
            return max_val;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/acc_add_core.sv
// rtl/acc_add_core.sv - combinational WIDTH-bit adder with carry out
module acc_add_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - packet accumulator with held result word; ADDER_ACCUMULATOR_SAT_EN selects saturating sum
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] carries;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] next_acc;
    logic             beat_accept;

    acc_add_core #(.WIDTH(WIDTH)) u_add_core (
        .a         (acc),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

`ifdef ADDER_ACCUMULATOR_SAT_EN
    assign next_acc = add_carry ? {WIDTH{1'b1}} : add_sum;
`else
    assign next_acc = add_sum;
`endif

    assign in_ready    = (state != HOLD);
    assign out_valid   = (state == HOLD);
    assign beat_accept = in_valid && in_ready;
    assign out_sum     = acc;
    assign out_carries = carries;
    assign out_count   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat_accept) begin
                        acc   <= next_acc;
                        count <= CNT_W'(sat_inc(32'(count), CNT_W));
                        if (add_carry) begin
                            carries <= CNT_W'(sat_inc(32'(carries), CNT_W));
                        end
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    // Clearing here means the next packet always starts from zero.
                    if (out_ready) begin
                        acc     <= '0;
                        carries <= '0;
                        count   <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - randomized scoreboard bench for adder_accumulator (CNT_W=4 and CNT_W=2 instances)
module tb_adder_accumulator;

    typedef struct {
        int sum;
        int carries;
        int count;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_in_valid = 1'b0, a_in_last = 1'b0;
    logic [3:0] a_in_data = '0;
    logic       a_in_ready, a_out_valid, a_out_ready;
    logic [3:0] a_out_sum, a_out_carries, a_out_count;

    logic       b_in_valid = 1'b0, b_in_last = 1'b0;
    logic [3:0] b_in_data = '0;
    logic       b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_out_sum;
    logic [1:0] b_out_carries, b_out_count;

    logic rdy_random = 1'b0;
    logic rdy_force  = 1'b1;
    logic rnd_a = 1'b1, rnd_b = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   pkt[$];

    assign a_out_ready = rdy_random ? rnd_a : rdy_force;
    assign b_out_ready = rdy_random ? rnd_b : rdy_force;

    adder_accumulator #(.WIDTH(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_carries(a_out_carries), .out_count(a_out_count)
    );

    adder_accumulator #(.WIDTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_carries(b_out_carries), .out_count(b_out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_a = 1'($urandom_range(0, 1));
        rnd_b = 1'($urandom_range(0, 1));
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: integer running sum, a carry whenever it reaches 2^4, counters clamp at cnt_max.
    function automatic exp_t model(input int cnt_max);
        exp_t e;
        int s = 0;
        int c = 0;
        foreach (pkt[i]) begin
            s = s + pkt[i];
            if (s >= 16) begin
                c++;
`ifdef ADDER_ACCUMULATOR_SAT_EN
                s = 15;
`else
                s = s - 16;
`endif
            end
        end
        e.sum     = s;
        e.carries = (c > cnt_max) ? cnt_max : c;
        e.count   = (pkt.size() > cnt_max) ? cnt_max : pkt.size();
        return e;
    endfunction

    // Scoreboard monitors: compare while a result is presented, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && a_out_valid) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_result", 1, 0);
            end else begin
                check("a_sum", int'(a_out_sum), q_a[0].sum);
                check("a_carries", int'(a_out_carries), q_a[0].carries);
                check("a_count", int'(a_out_count), q_a[0].count);
                if (a_out_ready) void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_result", 1, 0);
            end else begin
                check("b_sum", int'(b_out_sum), q_b[0].sum);
                check("b_carries", int'(b_out_carries), q_b[0].carries);
                check("b_count", int'(b_out_count), q_b[0].count);
                if (b_out_ready) void'(q_b.pop_front());
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input int d, input logic l);
        if (sel) begin
            b_in_valid = v; b_in_data = 4'(d); b_in_last = l;
        end else begin
            a_in_valid = v; a_in_data = 4'(d); a_in_last = l;
        end
    endtask

    task automatic send_beat(input bit sel, input int d, input logic l, input int gap_max);
        bit got;
        int n = $urandom_range(0, gap_max);
        repeat (n) begin
            drive(sel, 1'b0, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        drive(sel, 1'b1, d, l);
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            got = sel ? b_in_ready : a_in_ready;
            @(posedge clk); #1;
        end
        if (!got) check("beat_accept_timeout", 0, 1);
        drive(sel, 1'b0, 0, 1'b0);
    endtask

    task automatic send_packet(input bit sel, input int gap_max);
        if (sel) q_b.push_back(model(3));
        else     q_a.push_back(model(15));
        foreach (pkt[i]) send_beat(sel, pkt[i], (i == pkt.size() - 1), gap_max);
        check(sel ? "b_latency_valid" : "a_latency_valid",
              int'(sel ? b_out_valid : a_out_valid), 1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && (q_a.size() + q_b.size()) != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", q_a.size() + q_b.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", int'(a_out_valid), 0);
        check("rst_a_ready", int'(a_in_ready), 1);
        check("rst_a_sum", int'(a_out_sum), 0);
        check("rst_a_count", int'(a_out_count), 0);
        check("rst_b_valid", int'(b_out_valid), 0);
        check("rst_b_ready", int'(b_in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pkt = '{5, 3};     send_packet(0, 0);
        pkt = '{7, 9};     send_packet(0, 0);
        pkt = '{15, 1, 15}; send_packet(0, 0);
        pkt = '{6};        send_packet(0, 2);

        // Backpressure: result must hold and input must stay blocked.
        wait_drain();
        rdy_force = 1'b0;
        pkt = '{9, 4};     send_packet(0, 0);
        repeat (3) begin
            check("bp_in_ready", int'(a_in_ready), 0);
            check("bp_out_valid", int'(a_out_valid), 1);
            drive(0, 1'b1, 7, 1'b1);
            @(posedge clk); #1;
        end
        rdy_force = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 1'b0);
        check("bp_release_in_ready", int'(a_in_ready), 1);
        check("bp_release_out_valid", int'(a_out_valid), 0);
        pkt = '{2, 3};     send_packet(0, 0);

        // Reset in the middle of a packet discards it.
        wait_drain();
        send_beat(0, 4, 1'b0, 0);
        send_beat(0, 4, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(a_out_valid), 0);
        check("midrst_sum", int'(a_out_sum), 0);
        check("midrst_count", int'(a_out_count), 0);
        check("midrst_carries", int'(a_out_carries), 0);
        check("midrst_in_ready", int'(a_in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pkt = '{2};        send_packet(0, 0);

        // Narrow counters saturate at 3.
        pkt = '{0, 0, 0, 0, 0}; send_packet(1, 0);
        pkt = '{0, 0, 0, 0, 0}; send_packet(1, 3);
        pkt = '{15, 15, 15, 15, 15}; send_packet(1, 1);
        wait_drain();

        rdy_random = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int len = $urandom_range(1, 20);
            pkt = {};
            for (int i = 0; i < len; i++) pkt.push_back((p % 4 == 0) ? 15 : $urandom_range(0, 15));
            send_packet(0, $urandom_range(0, 3));
            len = $urandom_range(1, 6);
            pkt = {};
            for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 15));
            send_packet(1, $urandom_range(0, 3));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
